// File: rtl/grng_stream_pkg.sv
// Shared types and defaults for the GRNG sample streamer.
// State encoding, default sizing and the sample centring helper.
package grng_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    WARM = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_SEED_CYCLES = 2;
  localparam int DEF_WARMUP      = 32;

  // Offset-binary to two's complement: flip bit msb.
  // Width-agnostic; callers widen and truncate.
  function automatic logic [63:0] center_map(
    input logic [63:0] sample,
    input int          msb,
    input bit          center
  );
    center_map = center ? (sample ^ (64'd1 << msb))
                        : sample;
  endfunction

endpackage

// File: rtl/grng_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports: clk, rst, flush, push/pushData, pop/popData, full, empty, count.
module grng_sync_fifo
  import grng_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        pushData,
  input  logic                     pop,
  output logic [DATA_W-1:0]        popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr;
  logic [AW-1:0]     rdPtr;
  logic [AW:0]       cnt;
  logic              doPop;
  logic              doPush;

  assign full   = (cnt == (AW+1)'(DEPTH));
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign doPop  = pop && !empty;
  // A full FIFO still accepts when a pop frees a slot.
  assign doPush = push && (!full || doPop);

  assign popData = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      unique case ({doPush, doPop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/grng_sample_streamer.sv
// Seeds a GRNG, discards warm-up output, streams samples via a FIFO.
// Ports: clk, rst, start, stop, ld_seed, grng_result, m_valid/m_ready/m_data, fill, ovf_cnt, state_o.
module grng_sample_streamer
  import grng_stream_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SEED_CYCLES = DEF_SEED_CYCLES,
  parameter int WARMUP      = DEF_WARMUP,
  parameter int CENTER      = 1,
  parameter int OVF_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  output logic                   ld_seed,
  input  logic [DATA_W-1:0]      grng_result,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic [$clog2(DEPTH):0] fill,
  output logic [OVF_W-1:0]       ovf_cnt,
  output logic [1:0]             state_o
);

  localparam int CNT_MAX =
    (SEED_CYCLES > WARMUP) ? SEED_CYCLES : WARMUP;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SEED_LAST =
    CNT_W'(SEED_CYCLES - 1);
  localparam logic [CNT_W-1:0] WARM_LAST =
    CNT_W'(WARMUP - 1);

  state_t            state;
  state_t            nextState;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  nextCnt;
  logic              capture;
  logic              flush;
  logic              full;
  logic              empty;
  logic              popFire;
  logic              drop;
  logic [DATA_W-1:0] pushData;

  assign pushData = DATA_W'(center_map(
    64'(grng_result), DATA_W - 1, CENTER != 0));

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    capture   = 1'b0;
    flush     = 1'b0;
    if (start) begin
      nextState = SEED;
      nextCnt   = '0;
      flush     = 1'b1;
    end else if (stop && state != IDLE) begin
      nextState = IDLE;
      nextCnt   = '0;
    end else begin
      unique case (state)
        IDLE: nextState = IDLE;
        SEED: begin
          if (cnt == SEED_LAST) begin
            nextCnt   = '0;
            nextState = (WARMUP == 0) ? RUN : WARM;
          end else begin
            nextCnt = cnt + CNT_W'(1);
          end
        end
        WARM: begin
          if (cnt == WARM_LAST) begin
            nextCnt   = '0;
            nextState = RUN;
          end else begin
            nextCnt = cnt + CNT_W'(1);
          end
        end
        RUN: capture = 1'b1;
      endcase
    end
  end

  assign popFire = m_valid && m_ready;
  assign drop    = capture && full && !popFire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ld_seed <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      state   <= nextState;
      cnt     <= nextCnt;
      ld_seed <= (nextState == SEED);
      if (drop && ovf_cnt != '1) begin
        ovf_cnt <= ovf_cnt + OVF_W'(1);
      end
    end
  end

  grng_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (capture),
    .pushData (pushData),
    .pop      (m_ready),
    .popData  (m_data),
    .full     (full),
    .empty    (empty),
    .count    (fill)
  );

  assign m_valid = !empty;
  assign state_o = state;

endmodule

// File: tb/tb_grng_sample_streamer.sv
// Bench for grng_sample_streamer: vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_grng_sample_streamer;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int SEEDC = 2;
  localparam int WARMC = 32;
  localparam int OVFMX = 65535;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mReady = 1'b0;
  logic [DW-1:0] res = '0;
  logic          ldSeed;
  logic          mValid;
  logic [DW-1:0] mData;
  logic [4:0]    fill;
  logic [15:0]   ovfCnt;
  logic [1:0]    stateO;

  int checks = 0;
  int failures = 0;

  int            mState = 0;
  int            mCnt = 0;
  int            mOvf = 0;
  logic [DW-1:0] q[$];

  always #5 clk = ~clk;

  grng_sample_streamer #(
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .SEED_CYCLES (SEEDC),
    .WARMUP      (WARMC),
    .CENTER      (1),
    .OVF_W       (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .ld_seed     (ldSeed),
    .grng_result (res),
    .m_valid     (mValid),
    .m_ready     (mReady),
    .m_data      (mData),
    .fill        (fill),
    .ovf_cnt     (ovfCnt),
    .state_o     (stateO)
  );

  function automatic logic [DW-1:0] cmap(input logic [DW-1:0] s);
    return {~s[DW-1], s[DW-2:0]};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: phase countdown plus a sample queue.
  task automatic modelUpdate();
    bit popped;
    popped = mReady && (q.size() != 0);
    if (rst) begin
      mState = 0;
      mCnt   = 0;
      mOvf   = 0;
      q.delete();
    end else if (start) begin
      q.delete();
      mState = 1;
      mCnt   = SEEDC;
    end else begin
      if (popped) void'(q.pop_front());
      if (stop && mState != 0) begin
        mState = 0;
      end else begin
        case (mState)
          1: begin
            mCnt--;
            if (mCnt == 0) begin
              if (WARMC == 0) mState = 3;
              else begin
                mState = 2;
                mCnt   = WARMC;
              end
            end
          end
          2: begin
            mCnt--;
            if (mCnt == 0) mState = 3;
          end
          3: begin
            if (q.size() < DEPTH) q.push_back(cmap(res));
            else if (mOvf < OVFMX) mOvf++;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic modelCheck();
    chk("state_o", 32'(stateO), 32'(mState));
    chk("ld_seed", 32'(ldSeed), 32'(mState == 1));
    chk("m_valid", 32'(mValid), 32'(q.size() != 0));
    chk("m_data", 32'(mData),
        (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk("fill", 32'(fill), 32'(q.size()));
    chk("ovf_cnt", 32'(ovfCnt), 32'(mOvf));
  endtask

  task automatic cyc(input logic s, input logic sp,
                     input logic r, input logic rdy,
                     input logic [DW-1:0] d);
    start  = s;
    stop   = sp;
    rst    = r;
    mReady = rdy;
    res    = d;
    modelUpdate();
    @(posedge clk);
    #1;
    modelCheck();
  endtask

  task automatic runTo();
    cyc(1, 0, 0, 0, DW'($urandom));
    repeat (SEEDC + WARMC) cyc(0, 0, 0, 0, DW'($urandom));
  endtask

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] expData;
    int            expFill;
  } vec_t;

  vec_t          vt[3];
  logic [DW-1:0] samp[20];
  logic [DW-1:0] held;
  int            expS;

  initial begin
    vt[0] = '{8'h80, 8'h00, 1};
    vt[1] = '{8'h00, 8'h80, 1};
    vt[2] = '{8'hFF, 8'h7F, 1};

    // reset
    cyc(0, 0, 1, 0, 8'h00);
    chk("rst_state", 32'(stateO), 32'd0);
    chk("rst_ld", 32'(ldSeed), 32'd0);
    chk("rst_valid", 32'(mValid), 32'd0);
    chk("rst_data", 32'(mData), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_ovf", 32'(ovfCnt), 32'd0);
    cyc(0, 0, 0, 0, 8'h00);

    // seed / warm-up timeline
    cyc(1, 0, 0, 0, DW'($urandom));
    chk("seq_state0", 32'(stateO), 32'd1);
    chk("seq_ld0", 32'(ldSeed), 32'd1);
    for (int k = 1; k <= SEEDC + WARMC; k++) begin
      cyc(0, 0, 0, 0, DW'($urandom));
      expS = (k < SEEDC) ? 1 : (k < SEEDC + WARMC) ? 2 : 3;
      chk("seq_state", 32'(stateO), 32'(expS));
      chk("seq_ld", 32'(ldSeed), 32'(expS == 1));
      chk("seq_valid", 32'(mValid), 32'd0);
    end

    // centring vectors
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, vt[i].din);
      chk("tbl_data", 32'(mData), 32'(vt[i].expData));
      chk("tbl_fill", 32'(fill), 32'(vt[i].expFill));
      chk("tbl_valid", 32'(mValid), 32'd1);
    end

    // fill and overflow
    runTo();
    for (int i = 0; i < 20; i++) begin
      samp[i] = DW'($urandom);
      cyc(0, 0, 0, 0, samp[i]);
      chk("ovf_hold", 32'(mData), 32'(cmap(samp[0])));
    end
    chk("ovf_fill", 32'(fill), 32'd16);
    chk("ovf_cnt4", 32'(ovfCnt), 32'd4);

    // full with one pop
    cyc(0, 0, 0, 1, DW'($urandom));
    chk("full_pop_fill", 32'(fill), 32'd16);
    chk("full_pop_ovf", 32'(ovfCnt), 32'd4);
    chk("full_pop_data", 32'(mData), 32'(cmap(samp[1])));

    // restart with fill 9
    runTo();
    repeat (9) cyc(0, 0, 0, 0, DW'($urandom));
    chk("pre_fill9", 32'(fill), 32'd9);
    cyc(1, 0, 0, 0, DW'($urandom));
    chk("rs_fill", 32'(fill), 32'd0);
    chk("rs_valid", 32'(mValid), 32'd0);
    chk("rs_ld", 32'(ldSeed), 32'd1);
    chk("rs_ovf", 32'(ovfCnt), 32'd4);

    // reset during warm-up
    repeat (5) cyc(0, 0, 0, 0, DW'($urandom));
    chk("in_warm", 32'(stateO), 32'd2);
    cyc(0, 0, 1, 1, DW'($urandom));
    chk("wr_state", 32'(stateO), 32'd0);
    chk("wr_ld", 32'(ldSeed), 32'd0);
    chk("wr_ovf", 32'(ovfCnt), 32'd0);
    chk("wr_data", 32'(mData), 32'd0);

    // stop in RUN keeps the FIFO
    runTo();
    repeat (3) cyc(0, 0, 0, 0, DW'($urandom));
    held = mData;
    cyc(0, 1, 0, 0, DW'($urandom));
    chk("stop_state", 32'(stateO), 32'd0);
    chk("stop_fill", 32'(fill), 32'd3);
    chk("stop_data", 32'(mData), 32'(held));
    repeat (2) cyc(0, 0, 0, 0, DW'($urandom));
    chk("idle_fill", 32'(fill), 32'd3);

    // stop during SEED; start+stop together
    cyc(1, 0, 0, 0, DW'($urandom));
    cyc(0, 1, 0, 0, DW'($urandom));
    chk("ss_state", 32'(stateO), 32'd0);
    chk("ss_ld", 32'(ldSeed), 32'd0);
    cyc(1, 1, 0, 0, DW'($urandom));
    chk("both_state", 32'(stateO), 32'd1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 149) == 0,
          $urandom_range(0, 399) == 0,
          $urandom_range(0, 3) != 0 && (i % 400) > 100,
          DW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
